// File: rtl/stroke_history_buffer.sv
// Undo/redo history for the canvas pixel stream: logs committed pixels and replays strokes as a valid/ready stream.
// Optional STROKE_HISTORY_GROUP_EN: replay whole strokes bounded by stroke_start; otherwise one entry per request.
module stroke_history_buffer #(
  parameter int unsigned COORD_W = 8,
  parameter int unsigned COLOR_W = 3,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               save,
  output logic               save_ready,
  input  logic               stroke_start,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic [COLOR_W-1:0] old_color,
  input  logic [COLOR_W-1:0] new_color,
  input  logic               undo,
  input  logic               redo,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [COLOR_W-1:0] out_color,
  output logic               out_is_undo,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               can_undo,
  output logic               can_redo,
  output logic [PTR_W:0]     undo_cnt
);

  localparam int unsigned CNT_W = PTR_W + 1;

`ifdef STROKE_HISTORY_GROUP_EN
  typedef struct packed {
    logic               start;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] old_c;
    logic [COLOR_W-1:0] new_c;
  } entry_t;
`else
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] old_c;
    logic [COLOR_W-1:0] new_c;
  } entry_t;
`endif

  typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_t;

  state_t             state_q, state_d;
  logic               mode_undo_q, mode_undo_d;
  logic [PTR_W-1:0]   cur_q, cur_d;
  logic [CNT_W-1:0]   undo_cnt_q, undo_cnt_d;
  logic [CNT_W-1:0]   redo_cnt_q, redo_cnt_d;
  logic [COORD_W-1:0] out_x_q, out_x_d, out_y_q, out_y_d;
  logic [COLOR_W-1:0] out_color_q, out_color_d;
  logic               out_is_undo_q, out_is_undo_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               save_ready_q, save_ready_d;
  logic               can_undo_q, can_undo_d;
  logic               can_redo_q, can_redo_d;

  entry_t             mem [DEPTH];
  entry_t             wr_entry_c, rd_entry_c;
  logic [PTR_W-1:0]   rd_idx_c;
  logic               mem_we_c;
  logic               undo_stop_c, redo_stop_c;

  assign rd_idx_c   = mode_undo_q ? PTR_W'(cur_q - PTR_W'(1)) : cur_q;
  assign rd_entry_c = mem[rd_idx_c];

`ifdef STROKE_HISTORY_GROUP_EN
  logic start_q, start_d;
  entry_t nxt_entry_c;
  assign wr_entry_c  = '{start: stroke_start, x: x_in, y: y_in, old_c: old_color, new_c: new_color};
  assign nxt_entry_c = mem[PTR_W'(cur_q + PTR_W'(1))];
  // Undo stops at a stroke head; redo stops before the next stroke head.
  assign undo_stop_c = start_q || (undo_cnt_q == CNT_W'(1));
  assign redo_stop_c = (redo_cnt_q == CNT_W'(1)) || nxt_entry_c.start;
`else
  logic unused_stroke_start;
  assign unused_stroke_start = stroke_start;
  assign wr_entry_c  = '{x: x_in, y: y_in, old_c: old_color, new_c: new_color};
  assign undo_stop_c = 1'b1;
  assign redo_stop_c = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (mem_we_c) mem[cur_q] <= wr_entry_c;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    mode_undo_d   = mode_undo_q;
    cur_d         = cur_q;
    undo_cnt_d    = undo_cnt_q;
    redo_cnt_d    = redo_cnt_q;
    out_x_d       = out_x_q;
    out_y_d       = out_y_q;
    out_color_d   = out_color_q;
    out_is_undo_d = out_is_undo_q;
    mem_we_c      = 1'b0;
`ifdef STROKE_HISTORY_GROUP_EN
    start_d       = start_q;
`endif
    case (state_q)
      IDLE: begin
        if (save) begin
          mem_we_c   = 1'b1;
          cur_d      = PTR_W'(cur_q + PTR_W'(1));
          redo_cnt_d = '0;
          if (undo_cnt_q != CNT_W'(DEPTH)) undo_cnt_d = CNT_W'(undo_cnt_q + CNT_W'(1));
        end else if (undo && (undo_cnt_q != '0)) begin
          mode_undo_d = 1'b1;
          state_d     = FETCH;
        end else if (redo && (redo_cnt_q != '0)) begin
          mode_undo_d = 1'b0;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        out_x_d       = rd_entry_c.x;
        out_y_d       = rd_entry_c.y;
        out_color_d   = mode_undo_q ? rd_entry_c.old_c : rd_entry_c.new_c;
        out_is_undo_d = mode_undo_q;
`ifdef STROKE_HISTORY_GROUP_EN
        start_d       = rd_entry_c.start;
`endif
        state_d       = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          if (mode_undo_q) begin
            cur_d      = PTR_W'(cur_q - PTR_W'(1));
            undo_cnt_d = CNT_W'(undo_cnt_q - CNT_W'(1));
            redo_cnt_d = CNT_W'(redo_cnt_q + CNT_W'(1));
            state_d    = undo_stop_c ? IDLE : FETCH;
          end else begin
            cur_d      = PTR_W'(cur_q + PTR_W'(1));
            redo_cnt_d = CNT_W'(redo_cnt_q - CNT_W'(1));
            if (undo_cnt_q != CNT_W'(DEPTH)) undo_cnt_d = CNT_W'(undo_cnt_q + CNT_W'(1));
            state_d    = redo_stop_c ? IDLE : FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d  = (state_d == EMIT);
    busy_d       = (state_d != IDLE);
    save_ready_d = (state_d == IDLE);
    can_undo_d   = (undo_cnt_d != '0);
    can_redo_d   = (redo_cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mode_undo_q   <= 1'b0;
      cur_q         <= '0;
      undo_cnt_q    <= '0;
      redo_cnt_q    <= '0;
      out_x_q       <= '0;
      out_y_q       <= '0;
      out_color_q   <= '0;
      out_is_undo_q <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      save_ready_q  <= 1'b1;
      can_undo_q    <= 1'b0;
      can_redo_q    <= 1'b0;
`ifdef STROKE_HISTORY_GROUP_EN
      start_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mode_undo_q   <= mode_undo_d;
      cur_q         <= cur_d;
      undo_cnt_q    <= undo_cnt_d;
      redo_cnt_q    <= redo_cnt_d;
      out_x_q       <= out_x_d;
      out_y_q       <= out_y_d;
      out_color_q   <= out_color_d;
      out_is_undo_q <= out_is_undo_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
      save_ready_q  <= save_ready_d;
      can_undo_q    <= can_undo_d;
      can_redo_q    <= can_redo_d;
`ifdef STROKE_HISTORY_GROUP_EN
      start_q       <= start_d;
`endif
    end
  end

  assign save_ready  = save_ready_q;
  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign out_color   = out_color_q;
  assign out_is_undo = out_is_undo_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign can_undo    = can_undo_q;
  assign can_redo    = can_redo_q;
  assign undo_cnt    = undo_cnt_q;

endmodule

// File: tb/tb_stroke_history_buffer.sv
// Scoreboard bench for stroke_history_buffer; expected beats come from a behavioural history model.
module tb_stroke_history_buffer;

  localparam int unsigned CW = 8;
  localparam int unsigned KW = 3;
  localparam int D = 16;
`ifdef STROKE_HISTORY_GROUP_EN
  localparam bit GROUP = 1'b1;
`else
  localparam bit GROUP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic save = 1'b0, stroke_start = 1'b0, undo = 1'b0, redo = 1'b0, rdy = 1'b1;
  logic [CW-1:0] x_in = '0, y_in = '0;
  logic [KW-1:0] old_color = '0, new_color = '0;
  logic save_ready, out_is_undo, out_valid, busy, can_undo, can_redo;
  logic [CW-1:0] out_x, out_y;
  logic [KW-1:0] out_color;
  logic [4:0] undo_cnt;

  stroke_history_buffer dut (
    .clk(clk), .rst_n(rst_n), .save(save), .save_ready(save_ready),
    .stroke_start(stroke_start), .x_in(x_in), .y_in(y_in),
    .old_color(old_color), .new_color(new_color), .undo(undo), .redo(redo),
    .out_x(out_x), .out_y(out_y), .out_color(out_color), .out_is_undo(out_is_undo),
    .out_valid(out_valid), .out_ready(rdy), .busy(busy), .can_undo(can_undo),
    .can_redo(can_redo), .undo_cnt(undo_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [CW-1:0] x, y; logic [KW-1:0] oc, nc; logic st; } ment_t;
  typedef struct { logic [CW-1:0] x, y; logic [KW-1:0] c; logic u; } beat_t;

  ment_t m_mem [D];
  int m_cur = 0, m_ucnt = 0, m_rcnt = 0;
  beat_t exp_q [$];
  int total = 0, bad = 0, beats = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && rdy) begin
      beats++;
      if (exp_q.size() == 0) begin
        check_eq("beat_avail", 32'(exp_q.size()), 32'd1);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check_eq("beat", 32'({out_x, out_y, out_color, out_is_undo}), 32'({e.x, e.y, e.c, e.u}));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_save(input logic [CW-1:0] x, input logic [CW-1:0] y,
                            input logic [KW-1:0] oc, input logic [KW-1:0] nc, input logic st);
    m_mem[m_cur] = '{x: x, y: y, oc: oc, nc: nc, st: st};
    m_cur  = (m_cur + 1) % D;
    m_rcnt = 0;
    if (m_ucnt < D) m_ucnt++;
  endtask

  task automatic model_undo();
    bit stop;
    int idx;
    if (m_ucnt == 0) return;
    do begin
      idx = (m_cur + D - 1) % D;
      exp_q.push_back('{x: m_mem[idx].x, y: m_mem[idx].y, c: m_mem[idx].oc, u: 1'b1});
      m_cur = idx;
      m_ucnt--;
      m_rcnt++;
      stop = !GROUP || m_mem[idx].st || (m_ucnt == 0);
    end while (!stop);
  endtask

  task automatic model_redo();
    bit stop;
    int idx;
    if (m_rcnt == 0) return;
    do begin
      idx = m_cur;
      exp_q.push_back('{x: m_mem[idx].x, y: m_mem[idx].y, c: m_mem[idx].nc, u: 1'b0});
      m_cur = (m_cur + 1) % D;
      m_rcnt--;
      if (m_ucnt < D) m_ucnt++;
      stop = !GROUP || (m_rcnt == 0) || m_mem[m_cur].st;
    end while (!stop);
  endtask

  task automatic drive_px(input int x, input int y, input int oc, input int nc, input bit st);
    x_in = CW'(x); y_in = CW'(y); old_color = KW'(oc); new_color = KW'(nc); stroke_start = st;
  endtask

  task automatic do_save(input int x, input int y, input int oc, input int nc, input bit st);
    drive_px(x, y, oc, nc, st);
    save = 1'b1;
    model_save(CW'(x), CW'(y), KW'(oc), KW'(nc), st);
    tick();
    save = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_ucnt"}, 32'(undo_cnt), 32'(m_ucnt));
    check_eq({tag, "_flags"}, 32'({save_ready, can_undo, can_redo}),
             32'({1'b1, m_ucnt != 0, m_rcnt != 0}));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin tick(); n++; end
    if (n >= 300) check_eq({tag, "_timeout"}, 32'(busy), 32'd0);
    check_eq({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic req(input bit is_undo, input string tag);
    if (is_undo) begin undo = 1'b1; model_undo(); end
    else         begin redo = 1'b1; model_redo(); end
    tick();
    undo = 1'b0;
    redo = 1'b0;
    wait_idle(tag);
    check_counts(tag);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check_eq({tag, "_ov_seen"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    int b0, guard;
    logic [18:0] cap;
    // Reset state
    #12 rst_n = 1'b1;
    tick();
    check_eq("rst_outs", 32'({save_ready, out_valid, busy, can_undo, can_redo, undo_cnt}),
             32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0}));

    // Test 1: three-pixel stroke, undo
    do_save(10, 20, 1, 5, 1'b1);
    do_save(11, 21, 2, 6, 1'b0);
    do_save(12, 22, 3, 7, 1'b0);
    check_counts("t1_saved");
    req(1'b1, "t1_undo");

    // Test 2: redo with latency check (request in cycle n, out_valid in n+2)
    redo = 1'b1;
    model_redo();
    @(negedge clk);
    check_eq("t2_lat_n", 32'(out_valid), 32'd0);
    tick();
    redo = 1'b0;
    @(negedge clk);
    check_eq("t2_lat_n1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq("t2_lat_n2", 32'(out_valid), 32'd1);
    tick();
    wait_idle("t2_redo");
    check_counts("t2_redo");

    // Test 3: overflow the history, then drain it
    for (int i = 0; i < 20; i++) do_save(i, i + 100, i % 8, (i + 1) % 8, i == 0);
    check_eq("t3_ucnt_sat", 32'(undo_cnt), 32'd16);
    guard = 0;
    while (m_ucnt > 0 && guard < 20) begin req(1'b1, "t3_undo"); guard++; end
    check_eq("t3_can_undo", 32'(can_undo), 32'd0);
    b0 = beats;
    req(1'b1, "t3_empty_undo");
    check_eq("t3_noop_beats", 32'(beats - b0), 32'd0);

    // Test 4: back-pressure during undo
    do_save(40, 50, 1, 2, 1'b1);
    do_save(41, 51, 3, 4, 1'b0);
    do_save(42, 52, 5, 6, 1'b0);
    rdy = 1'b0;
    undo = 1'b1;
    model_undo();
    tick();
    undo = 1'b0;
    wait_valid("t4");
    cap = {out_x, out_y, out_color};
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        redo = 1'b1; save = 1'b1;
        drive_px(99, 99, 7, 7, 1'b1);
      end
      @(negedge clk);
      check_eq("t4_stall", 32'({save_ready, out_valid, out_x, out_y, out_color}),
               32'({1'b0, 1'b1, cap}));
      tick();
      redo = 1'b0; save = 1'b0;
    end
    rdy = 1'b1;
    wait_idle("t4_undo");
    check_counts("t4_undo");

    // Test 5: save and undo together -> save wins
    drive_px(60, 61, 2, 3, 1'b1);
    save = 1'b1; undo = 1'b1;
    model_save(CW'(60), CW'(61), KW'(2), KW'(3), 1'b1);
    b0 = beats;
    tick();
    save = 1'b0; undo = 1'b0;
    tick(); tick();
    check_eq("t5_no_replay", 32'({busy, beats - b0}), 32'd0);
    check_counts("t5_save");

    // Test 6: reset mid-replay, then single stroke undo
    do_save(70, 80, 1, 2, 1'b1);
    do_save(71, 81, 3, 4, 1'b0);
    do_save(72, 82, 5, 6, 1'b0);
    rdy = 1'b0;
    undo = 1'b1;
    model_undo();
    tick();
    undo = 1'b0;
    wait_valid("t6");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_eq("t6_rst", 32'({out_valid, busy, can_undo, can_redo, undo_cnt}), 32'd0);
    exp_q.delete();
    m_cur = 0; m_ucnt = 0; m_rcnt = 0;
    tick();
    rst_n = 1'b1;
    rdy = 1'b1;
    tick();
    check_counts("t6_after_rst");
    do_save(1, 2, 3, 4, 1'b1);
    do_save(5, 6, 7, 0, 1'b0);
    do_save(9, 10, 1, 2, 1'b0);
    b0 = beats;
    req(1'b1, "t6_undo");
    check_eq("t6_beats", 32'(beats - b0), GROUP ? 32'd3 : 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
